// File: rtl/fpcvt_sched.sv
// fpcvt_sched: round-robin scheduler that shares one iterative converter.
// The converter turns a 12-bit two's complement sample into an 8-bit float
// {sign, E[2:0], F[3:0]} whose value is F * 2^E.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active low
//   req_valid  per-requester "sample available"
//   req_ready  one-hot accept strobe (combinational, IDLE only)
//   req_data   packed samples, sample i = req_data[12*i+11:12*i]
//   out_valid  result available
//   out_ready  consumer accepts result
//   out_id     requester index of the result
//   out_sign   sign bit
//   out_exp    exponent E
//   out_sig    significand F
//   busy       converter occupied (NORM, ROUND or HOLD)
module fpcvt_sched #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [12*NREQ-1:0] req_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_id,
  output logic              out_sign,
  output logic [2:0]        out_exp,
  output logic [3:0]        out_sig,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_NORM  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [10:0]     mag_q, mag_d;
  logic [2:0]      exp_q, exp_d;
  logic            fifth_q, fifth_d;
  logic            sign_q, sign_d;
  logic [ID_W-1:0] id_q, id_d;

  logic            out_valid_q, out_valid_d;
  logic [ID_W-1:0] out_id_q, out_id_d;
  logic            out_sign_q, out_sign_d;
  logic [2:0]      out_exp_q, out_exp_d;
  logic [3:0]      out_sig_q, out_sig_d;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [NREQ-1:0] gnt_vec;
  logic [11:0]     gnt_data;
  logic [10:0]     samp_mag;
  logic [4:0]      rnd_sum;

  // Round-robin search: first the indices at or above the pointer, then the
  // ones below it. Equivalent to scanning ptr, ptr+1, ... mod NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_vec   = '0;
    gnt_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!gnt_found && req_valid[i] && (ID_W'(i) >= ptr_q)) begin
        gnt_found  = 1'b1;
        gnt_idx    = ID_W'(i);
        gnt_vec[i] = 1'b1;
        gnt_data   = req_data[12*i +: 12];
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!gnt_found && req_valid[i] && (ID_W'(i) < ptr_q)) begin
        gnt_found  = 1'b1;
        gnt_idx    = ID_W'(i);
        gnt_vec[i] = 1'b1;
        gnt_data   = req_data[12*i +: 12];
      end
    end
  end

  // -2048 has no 11-bit magnitude; clamp it to 2047.
  always_comb begin
    if (gnt_data[11]) begin
      samp_mag = (gnt_data == 12'h800) ? 11'h7FF : 11'(-gnt_data);
    end else begin
      samp_mag = gnt_data[10:0];
    end
  end

  always_comb begin
    rnd_sum = {1'b0, mag_q[3:0]} + {4'b0000, fifth_q};
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    fifth_d     = fifth_q;
    sign_d      = sign_q;
    id_d        = id_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_sign_d  = out_sign_q;
    out_exp_d   = out_exp_q;
    out_sig_d   = out_sig_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          sign_d  = gnt_data[11];
          mag_d   = samp_mag;
          id_d    = gnt_idx;
          exp_d   = '0;
          fifth_d = 1'b0;
          ptr_d   = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (|mag_q[10:4]) begin
          mag_d   = mag_q >> 1;
          exp_d   = exp_q + 3'd1;
          fifth_d = mag_q[0];
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        out_sign_d = sign_q;
        out_id_d   = id_q;
        // Rounding carry renormalises to 8 * 2^(E+1); at E=7 it saturates.
        if (rnd_sum[4]) begin
          if (exp_q == 3'd7) begin
            out_exp_d = 3'd7;
            out_sig_d = 4'd15;
          end else begin
            out_exp_d = exp_q + 3'd1;
            out_sig_d = 4'd8;
          end
        end else begin
          out_exp_d = exp_q;
          out_sig_d = rnd_sum[3:0];
        end
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      mag_q       <= '0;
      exp_q       <= '0;
      fifth_q     <= 1'b0;
      sign_q      <= 1'b0;
      id_q        <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_sig_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      fifth_q     <= fifth_d;
      sign_q      <= sign_d;
      id_q        <= id_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_sig_q   <= out_sig_d;
    end
  end

  // Accept strobe is gated by rst_n so it is low throughout reset.
  always_comb begin
    req_ready = (rst_n && (state_q == S_IDLE)) ? gnt_vec : '0;
    busy      = (state_q != S_IDLE);
    out_valid = out_valid_q;
    out_id    = out_id_q;
    out_sign  = out_sign_q;
    out_exp   = out_exp_q;
    out_sig   = out_sig_q;
  end

endmodule

// File: tb/tb_fpcvt_sched.sv
// tb_fpcvt_sched: self-checking bench for fpcvt_sched (NREQ=4, ID_W=2).
// Expected results come from an arithmetic reference conversion and a
// round-robin pointer model kept in the bench.
module tb_fpcvt_sched;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [12*NREQ-1:0] req_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ID_W-1:0]   out_id;
  logic              out_sign;
  logic [2:0]        out_exp;
  logic [3:0]        out_sig;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;
  logic [11:0] dat [NREQ];
  logic [11:0] corners [8] = '{12'h800, 12'h7FF, 12'h000, 12'hFFF,
                               12'd15, 12'd16, 12'd248, 12'hFF0};

  fpcvt_sched #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_sig   (out_sig),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int bitlen(input int v);
    int n;
    n = 0;
    while (v > 0) begin
      v = v >> 1;
      n++;
    end
    return n;
  endfunction

  // Reference: value = F * 2^E with F in 0..15, round half up, saturate.
  function automatic void ref_conv(input logic [11:0] d, output int sg,
                                   output int e, output int f, output int k);
    int v, mag, r, s;
    v   = $signed(d);
    sg  = (v < 0) ? 1 : 0;
    mag = (v < 0) ? -v : v;
    if (mag > 2047) mag = 2047;
    k = (bitlen(mag) > 4) ? bitlen(mag) - 4 : 0;
    f = (mag >> k) & 15;
    r = (k > 0) ? ((mag >> (k - 1)) & 1) : 0;
    s = f + r;
    e = k;
    if (s == 16) begin
      f = 8;
      e = e + 1;
    end else begin
      f = s;
    end
    if (e == 8) begin
      e = 7;
      f = 15;
    end
  endfunction

  function automatic int grant(input logic [NREQ-1:0] m, input int p);
    for (int o = 0; o < NREQ; o++) begin
      int i;
      i = (p + o) % NREQ;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  task automatic load_data();
    for (int i = 0; i < NREQ; i++) req_data[12*i +: 12] = dat[i];
  endtask

  // Entered at IDLE, away from the clock edge; leaves one edge after handshake.
  task automatic do_conv(input logic [NREQ-1:0] mask, input int stall);
    int g, sg, e, f, k, cnt, expk;
    load_data();
    req_valid = mask;
    #1;
    g = grant(mask, ptr_m);
    chk("req_ready", req_ready, 1 << g);
    chk("busy_idle", busy, 0);
    ref_conv(dat[g], sg, e, f, k);
    @(posedge clk); #1;
    req_valid = '0;
    ptr_m = (g + 1) % NREQ;
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency", cnt, k + 2);
    chk("out_id", out_id, g);
    chk("out_sign", out_sign, sg);
    chk("out_exp", out_exp, e);
    chk("out_sig", out_sig, f);
    chk("busy_hold", busy, 1);
    expk = (1 << 10) | (g << 8) | (sg << 7) | (e << 4) | f;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      req_valid = NREQ'($urandom);
      #1;
      chk("hold_out", {out_valid, out_id, out_sign, out_exp, out_sig}, expk);
      chk("hold_ready", req_ready, 0);
      chk("hold_busy", busy, 1);
    end
    req_valid = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hs_valid", out_valid, 0);
    chk("hs_busy", busy, 0);
  endtask

  task automatic stream_test();
    int g, sg, e, f, k, cnt;
    logic [NREQ-1:0] mask;
    dat[0] = 12'd100;
    dat[1] = 12'hF00;
    dat[2] = 12'd5;
    dat[3] = 12'd1500;
    load_data();
    mask = '1;
    req_valid = mask;
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      g = grant(mask, ptr_m);
      ptr_m = (g + 1) % NREQ;
      ref_conv(dat[g], sg, e, f, k);
      cnt = 0;
      do begin
        @(posedge clk); #1;
        cnt++;
      end while (!out_valid && cnt < 40);
      chk("stream_gap", cnt, (n == 0) ? k + 3 : k + 4);
      chk("stream_id", out_id, g);
      chk("stream_res", {out_sign, out_exp, out_sig}, (sg << 7) | (e << 4) | f);
      if (n == 4) begin
        mask = 4'b0101;
        req_valid = mask;
      end
    end
    req_valid = '0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stream_end_busy", busy, 0);
  endtask

  task automatic reset_mid_op();
    int seen;
    dat[0] = 12'd1000;
    load_data();
    req_valid = 4'b0001;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    req_valid = 4'b0101;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    chk("no_stale", seen, 0);
    dat[0] = 12'd77;
    dat[2] = 12'hC00;
    do_conv(4'b0101, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) dat[i] = '0;
    req_valid = '1;
    #12;
    chk("reset_ready", req_ready, 0);
    chk("reset_out", {out_valid, out_id, out_sign, out_exp, out_sig}, 0);
    chk("reset_busy", busy, 0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    dat[0] = 12'd422;   do_conv(4'b0001, 0);
    dat[0] = 12'h800;   do_conv(4'b0001, 0);
    dat[0] = 12'd2047;  do_conv(4'b0001, 0);
    dat[0] = 12'd248;   do_conv(4'b0001, 0);
    dat[0] = 12'hFF3;   do_conv(4'b0001, 0);
    dat[0] = 12'd0;     do_conv(4'b0001, 0);
    dat[1] = 12'd300;   do_conv(4'b0010, 6);
    dat[3] = 12'd31;    do_conv(4'b1000, 1);

    stream_test();
    reset_mid_op();

    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0) dat[i] = corners[$urandom_range(0, 7)];
        else dat[i] = 12'($urandom);
      end
      do_conv(NREQ'($urandom_range(1, 15)), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
